// File: rtl/prescaler_ctrl.sv
// prescaler_ctrl
//   Run-time programmable prescaler controller. A divisor D (0 is treated as 1)
//   is loaded through a valid/ready handshake. start/stop sequence the block.
//   While running it emits a one-cycle `tick` every D cycles, and `clk_out`
//   toggles on each tick (period 2*D).
//
//   Optional feature macro: PRESCALER_CTRL_BURST_EN
//     When defined, a nonzero burst count B ends the run on the B-th tick and
//     pulses `done`. When undefined, cfg_burst is ignored and `done` is 0.
//
// Ports
//   clk        system clock
//   rstn       asynchronous active-low reset
//   cfg_valid  configuration offered
//   cfg_ready  configuration can be accepted (= !pending)
//   cfg_div    requested divisor (N bits)
//   cfg_burst  ticks per run, 0 = continuous (burst build only)
//   start      level-sampled run request
//   stop       level-sampled halt request (wins over start and over a tick)
//   tick       registered one-cycle pulse every D cycles
//   clk_out    registered 50 % duty square wave
//   busy       high while running
//   done       one-cycle pulse coincident with the final burst tick
module prescaler_ctrl #(
   parameter int unsigned N           = 16,
   parameter int unsigned DIV_DEFAULT = 4
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         cfg_valid,
   output logic         cfg_ready,
   input  logic [N-1:0] cfg_div,
   input  logic [7:0]   cfg_burst,
   input  logic         start,
   input  logic         stop,
   output logic         tick,
   output logic         clk_out,
   output logic         busy,
   output logic         done
);

   localparam logic [N-1:0] DIV_INIT = (DIV_DEFAULT == 0) ? N'(1) : N'(DIV_DEFAULT);

   typedef enum logic {IDLE, RUN} state_t;

   state_t       state;
   logic [N-1:0] cnt;
   logic [N-1:0] div_active;
   logic [N-1:0] shadow_div;
   logic [N-1:0] cfg_div_eff;
   logic [N-1:0] last;
   logic         pending;
   logic         accept;
   logic         at_last;

`ifdef PRESCALER_CTRL_BURST_EN
   logic [7:0]   burst_cnt;
   logic [7:0]   burst_shadow;
   logic [7:0]   burst_left;
   logic         done_r;
   assign done = done_r;
`else
   logic         unused_burst;
   assign unused_burst = ^cfg_burst;
   assign done         = 1'b0;
`endif

   assign cfg_ready   = ~pending;
   assign accept      = cfg_valid & ~pending;
   assign cfg_div_eff = (cfg_div == '0) ? N'(1) : cfg_div;
   // div_active is never 0, so this N-bit subtraction cannot wrap
   assign last        = div_active - N'(1);
   assign at_last     = (cnt == last);
   assign busy        = (state == RUN);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state        <= IDLE;
         cnt          <= '0;
         div_active   <= DIV_INIT;
         shadow_div   <= DIV_INIT;
         pending      <= 1'b0;
         tick         <= 1'b0;
         clk_out      <= 1'b0;
`ifdef PRESCALER_CTRL_BURST_EN
         burst_cnt    <= '0;
         burst_shadow <= '0;
         burst_left   <= '0;
         done_r       <= 1'b0;
`endif
      end else begin
         tick <= 1'b0;
`ifdef PRESCALER_CTRL_BURST_EN
         done_r <= 1'b0;
`endif
         case (state)
            IDLE: begin
               // A shadow value left over from an accept on the burst-ending
               // edge drains here so cfg_ready cannot stay low while idle.
               if (pending) begin
                  div_active <= shadow_div;
                  pending    <= 1'b0;
`ifdef PRESCALER_CTRL_BURST_EN
                  burst_cnt  <= burst_shadow;
`endif
               end
               if (accept) begin
                  div_active <= cfg_div_eff;
`ifdef PRESCALER_CTRL_BURST_EN
                  burst_cnt  <= cfg_burst;
`endif
               end
               if (start && !stop) begin
                  state <= RUN;
                  cnt   <= '0;
`ifdef PRESCALER_CTRL_BURST_EN
                  burst_left <= accept  ? cfg_burst :
                                pending ? burst_shadow : burst_cnt;
`endif
               end
            end

            RUN: begin
               if (stop) begin
                  state   <= IDLE;
                  cnt     <= '0;
                  clk_out <= 1'b0;
                  pending <= 1'b0;
                  if (accept) begin
                     div_active <= cfg_div_eff;
`ifdef PRESCALER_CTRL_BURST_EN
                     burst_cnt  <= cfg_burst;
`endif
                  end else if (pending) begin
                     div_active <= shadow_div;
`ifdef PRESCALER_CTRL_BURST_EN
                     burst_cnt  <= burst_shadow;
`endif
                  end
               end else begin
                  if (at_last) begin
                     cnt     <= '0;
                     tick    <= 1'b1;
                     clk_out <= ~clk_out;
                     if (pending) begin
                        div_active <= shadow_div;
                        pending    <= 1'b0;
`ifdef PRESCALER_CTRL_BURST_EN
                        burst_cnt  <= burst_shadow;
`endif
                     end
`ifdef PRESCALER_CTRL_BURST_EN
                     if (burst_left != 8'd0) begin
                        burst_left <= burst_left - 8'd1;
                        if (burst_left == 8'd1) begin
                           done_r  <= 1'b1;
                           state   <= IDLE;
                           clk_out <= 1'b0;
                        end
                     end
`endif
                  end else begin
                     cnt <= cnt + N'(1);
                  end
                  // accept implies !pending, so this never collides with the clear above
                  if (accept) begin
                     shadow_div   <= cfg_div_eff;
                     pending      <= 1'b1;
`ifdef PRESCALER_CTRL_BURST_EN
                     burst_shadow <= cfg_burst;
`endif
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_prescaler_ctrl.sv
// Self-checking bench for prescaler_ctrl. The reference model schedules ticks
// by absolute edge number (next tick = last tick edge + divisor) instead of
// counting cycles.
module tb_prescaler_ctrl;

   localparam int unsigned N = 16;

   logic         clk       = 1'b0;
   logic         rstn      = 1'b1;
   logic         cfg_valid = 1'b0;
   logic [N-1:0] cfg_div   = '0;
   logic [7:0]   cfg_burst = '0;
   logic         start     = 1'b0;
   logic         stop      = 1'b0;
   logic         cfg_ready;
   logic         tick;
   logic         clk_out;
   logic         busy;
   logic         done;

   int errors = 0;
   int checks = 0;

   prescaler_ctrl #(.N(N), .DIV_DEFAULT(4)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_div   (cfg_div),
      .cfg_burst (cfg_burst),
      .start     (start),
      .stop      (stop),
      .tick      (tick),
      .clk_out   (clk_out),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   // reference model
   bit          m_run, m_pending, m_tick, m_clk, m_done;
   int unsigned m_div, m_shadow, m_burst, m_bshadow, m_left;
   longint      m_next;
   longint      edge_no = 0;

   function automatic int unsigned eff(input int unsigned d);
      return (d == 0) ? 1 : d;
   endfunction

   task automatic model_reset();
      m_run = 0; m_pending = 0; m_tick = 0; m_clk = 0; m_done = 0;
      m_div = 4; m_shadow = 4; m_burst = 0; m_bshadow = 0; m_left = 0;
      m_next = 0;
   endtask

   task automatic model_edge();
      bit acc;
      edge_no++;
      acc = cfg_valid && !m_pending;
      if (!m_run) begin
         m_tick = 0; m_done = 0;
         if (m_pending) begin m_div = m_shadow; m_burst = m_bshadow; m_pending = 0; end
         if (acc) begin m_div = eff(cfg_div); m_burst = cfg_burst; end
         if (start && !stop) begin
            m_run = 1; m_next = edge_no + m_div; m_left = m_burst;
         end
      end else if (stop) begin
         m_run = 0; m_tick = 0; m_clk = 0; m_done = 0;
         if (acc) begin m_div = eff(cfg_div); m_burst = cfg_burst; end
         else if (m_pending) begin m_div = m_shadow; m_burst = m_bshadow; end
         m_pending = 0;
      end else begin
         m_done = 0;
         m_tick = (edge_no == m_next);
         if (m_tick) begin
            m_clk = !m_clk;
            if (m_pending) begin m_div = m_shadow; m_burst = m_bshadow; m_pending = 0; end
            m_next = edge_no + m_div;
`ifdef PRESCALER_CTRL_BURST_EN
            if (m_left != 0) begin
               m_left--;
               if (m_left == 0) begin m_done = 1; m_run = 0; m_clk = 0; end
            end
`endif
         end
         if (acc) begin m_shadow = eff(cfg_div); m_bshadow = cfg_burst; m_pending = 1; end
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, edge_no, obs, exp);
      end
   endtask

   task automatic compare_all();
      check("tick",      32'(tick),      32'(m_tick));
      check("clk_out",   32'(clk_out),   32'(m_clk));
      check("busy",      32'(busy),      32'(m_run));
      check("cfg_ready", 32'(cfg_ready), 32'(!m_pending));
      check("done",      32'(done),      32'(m_done));
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_tick"},       32'(tick),           32'd0);
      check({tag, "_clk_out"},    32'(clk_out),        32'd0);
      check({tag, "_busy"},       32'(busy),           32'd0);
      check({tag, "_done"},       32'(done),           32'd0);
      check({tag, "_cfg_ready"},  32'(cfg_ready),      32'd1);
      check({tag, "_div_active"}, 32'(dut.div_active), 32'd4);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic cyc(input bit v, input int unsigned d, input int unsigned b,
                      input bit s, input bit p);
      cfg_valid = v;
      cfg_div   = N'(d);
      cfg_burst = 8'(b);
      start     = s;
      stop      = p;
      step();
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
   endtask

   initial begin
      model_reset();
      #2 rstn = 1'b0;
      #6;
      check_reset_values("reset");
      @(posedge clk);
      #1 rstn = 1'b1;

      // reset divisor: tick every 4, clk_out period 8
      cyc(0, 0, 0, 1, 0);
      idle(17);
      cyc(0, 0, 0, 0, 1);

      // idle reconfiguration: D=3, then D=0 (treated as 1)
      cyc(1, 3, 0, 0, 0);
      cyc(0, 0, 0, 1, 0);
      idle(10);
      cyc(0, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0);
      idle(6);
      cyc(0, 0, 0, 0, 1);

      // running reconfiguration; the second offer finds pending set
      cyc(1, 5, 0, 0, 0);
      cyc(0, 0, 0, 1, 0);
      idle(2);
      cyc(1, 2, 0, 0, 0);
      cyc(1, 7, 0, 0, 0);
      idle(14);
      cyc(0, 0, 0, 0, 1);

      // stop on the would-be tick edge, then start+stop together in idle
      cyc(1, 3, 0, 0, 0);
      cyc(0, 0, 0, 1, 0);
      idle(2);
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 1, 1);
      idle(3);

      // burst D=2 B=3 (continuous when the burst feature is absent)
      cyc(1, 2, 3, 0, 0);
      cyc(0, 0, 0, 1, 0);
      idle(10);
      cyc(0, 0, 0, 0, 1);

      // asynchronous reset while D=7 is pending
      cyc(1, 5, 0, 0, 0);
      cyc(0, 0, 0, 1, 0);
      idle(2);
      cyc(1, 7, 0, 0, 0);
      cfg_valid = 1'b0;
      #2 rstn = 1'b0;
      #1;
      model_reset();
      check_reset_values("async_reset");
      #2 rstn = 1'b1;
      cyc(0, 0, 0, 1, 0);
      idle(9);

      // randomized traffic
      for (int i = 0; i < 800; i++) begin
         cyc($urandom_range(0, 6) == 0, $urandom_range(0, 9), $urandom_range(0, 4),
             $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
